// File: rtl/pulse_chk_pkg.sv
// Shared definitions for the pulse-counter output checker: FSM encoding, latency
// bound and saturating arithmetic.
package pulse_chk_pkg;

  localparam int unsigned LAT_MAX = 7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
    return (val >= max_val) ? max_val : val + 1;
  endfunction

endpackage

// File: rtl/counter_golden_model.sv
// Golden pulse-counter model plus a LAT-stage delay line matching the counter's
// output latency.
module counter_golden_model #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic             en,
  input  logic             rst,
  output logic [WIDTH-1:0] exp_count
);

  logic [WIDTH-1:0] m_q;

  // Clear has priority over increment, matching the counter under test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
    end else if (clr) begin
      m_q <= '0;
    end else if (upd) begin
      if (rst) begin
        m_q <= '0;
      end else if (en) begin
        m_q <= m_q + 1'b1;
      end
    end
  end

  if (LAT == 0) begin : g_no_delay
    assign exp_count = m_q;
  end else begin : g_delay
    logic [WIDTH-1:0] line_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) line_q[i] <= '0;
      end else if (clr) begin
        for (int i = 0; i < LAT; i++) line_q[i] <= '0;
      end else if (upd) begin
        line_q[0] <= m_q;
        for (int i = 1; i < LAT; i++) line_q[i] <= line_q[i-1];
      end
    end

    assign exp_count = line_q[LAT-1];
  end

endmodule

// File: rtl/counter4_out_checker.sv
// Self-checking consumer for the pulse counter: compares each readout against a
// delayed golden model and captures pass/fail, error count and first mismatch.
module counter4_out_checker
  import pulse_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned CYCW  = 16,
  parameter int unsigned ERRW  = 8
) (
  input  logic             GCLK_Pad,
  input  logic             rstn_Pad,
  input  logic             start_Pad,
  input  logic [CYCW-1:0]  num_cycles,
  input  logic             en_Pad,
  input  logic             rst_Pad,
  input  logic [WIDTH-1:0] count_Pad,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_cnt,
  output logic [CYCW-1:0]  first_err_cycle,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] exp_count
);

  localparam int unsigned LAT_EFF   = (LAT > LAT_MAX) ? LAT_MAX : LAT;
  localparam int unsigned ERR_MAX   = (32'd1 << ERRW) - 1;
  localparam logic [2:0]  FILL_LAST = 3'(LAT_EFF - 1);

  state_t           state_q, state_d;
  logic [2:0]       fill_q;
  logic [CYCW-1:0]  num_q, idx_q;
  logic [ERRW-1:0]  err_q, err_d;
  logic             pass_q;
  logic [CYCW-1:0]  fe_cycle_q;
  logic [WIDTH-1:0] fe_exp_q, fe_got_q;
  logic             start_ok, running, mismatch, last_cmp;

  assign start_ok = (state_q == ST_IDLE) && start_Pad;
  assign running  = (state_q == ST_FILL) || (state_q == ST_CHECK);
  assign mismatch = (state_q == ST_CHECK) && (count_Pad != exp_count);
  assign last_cmp = (idx_q == num_q - 1'b1);
  assign err_d    = mismatch ? ERRW'(sat_inc(32'(err_q), ERR_MAX)) : err_q;

  counter_golden_model #(
    .WIDTH (WIDTH),
    .LAT   (LAT_EFF)
  ) u_model (
    .clk       (GCLK_Pad),
    .rst_n     (rstn_Pad),
    .clr       (start_ok),
    .upd       (running),
    .en        (en_Pad),
    .rst       (rst_Pad),
    .exp_count (exp_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_Pad) begin
          if (LAT_EFF != 0)           state_d = ST_FILL;
          else if (num_cycles == '0)  state_d = ST_DONE;
          else                        state_d = ST_CHECK;
        end
      end
      ST_FILL: begin
        if (fill_q == FILL_LAST) state_d = (num_q == '0) ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        if (last_cmp) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge GCLK_Pad or negedge rstn_Pad) begin
    if (!rstn_Pad) begin
      state_q    <= ST_IDLE;
      fill_q     <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
      fe_cycle_q <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_q      <= num_cycles;
        fill_q     <= '0;
        idx_q      <= '0;
        err_q      <= '0;
        fe_cycle_q <= '0;
        fe_exp_q   <= '0;
        fe_got_q   <= '0;
        // A zero-length run with no fill goes straight to DONE and passes trivially.
        pass_q     <= (state_d == ST_DONE);
      end else begin
        if (state_q == ST_FILL) fill_q <= fill_q + 1'b1;
        if (state_q == ST_CHECK) begin
          idx_q <= idx_q + 1'b1;
          err_q <= err_d;
          // err_q never returns to zero once set, so it marks the first mismatch.
          if (mismatch && (err_q == '0)) begin
            fe_cycle_q <= idx_q;
            fe_exp_q   <= exp_count;
            fe_got_q   <= count_Pad;
          end
        end
        if (running && (state_d == ST_DONE)) pass_q <= (err_d == '0);
      end
    end
  end

  assign busy            = running;
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_cycle = fe_cycle_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;

endmodule

// File: tb/tb_counter4_out_checker.sv
// Directed and randomized runs of the checker (LAT=1/ERRW=8 and LAT=0/ERRW=3 instances).
module tb_counter4_out_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic [15:0] num;
  logic        en, rst;
  logic [3:0]  cnt;

  logic        busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [15:0] fec_a;
  logic [3:0]  fee_a, feg_a, exp_a;
  logic        busy_b, done_b, pass_b;
  logic [2:0]  err_b;
  logic [15:0] fec_b;
  logic [3:0]  fee_b, feg_b, exp_b;

  logic        sel;
  logic        c_busy, c_done, c_pass;
  logic [7:0]  c_err;
  logic [15:0] c_fec;
  logic [3:0]  c_fee, c_feg, c_exp;

  int checks = 0;
  int failures = 0;

  bit         en_arr  [0:63];
  bit         rst_arr [0:63];
  logic [3:0] exp_arr [0:63];
  logic [3:0] got_arr [0:63];

  always #5 clk = ~clk;

  counter4_out_checker #(.WIDTH(4), .LAT(1), .CYCW(16), .ERRW(8)) dut_a (
    .GCLK_Pad (clk), .rstn_Pad (rstn), .start_Pad (start_a), .num_cycles (num),
    .en_Pad (en), .rst_Pad (rst), .count_Pad (cnt),
    .busy (busy_a), .done (done_a), .pass (pass_a), .err_cnt (err_a),
    .first_err_cycle (fec_a), .first_err_exp (fee_a), .first_err_got (feg_a),
    .exp_count (exp_a)
  );

  counter4_out_checker #(.WIDTH(4), .LAT(0), .CYCW(16), .ERRW(3)) dut_b (
    .GCLK_Pad (clk), .rstn_Pad (rstn), .start_Pad (start_b), .num_cycles (num),
    .en_Pad (en), .rst_Pad (rst), .count_Pad (cnt),
    .busy (busy_b), .done (done_b), .pass (pass_b), .err_cnt (err_b),
    .first_err_cycle (fec_b), .first_err_exp (fee_b), .first_err_got (feg_b),
    .exp_count (exp_b)
  );

  always_comb begin
    c_busy = sel ? busy_b : busy_a;
    c_done = sel ? done_b : done_a;
    c_pass = sel ? pass_b : pass_a;
    c_err  = sel ? {5'd0, err_b} : err_a;
    c_fec  = sel ? fec_b : fec_a;
    c_fee  = sel ? fee_b : fee_a;
    c_feg  = sel ? feg_b : feg_a;
    c_exp  = sel ? exp_b : exp_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    checks++;
    assert (got === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: readout at compare j is the count after en/rst samples 1..j.
  task automatic build(input int mode, input int n, input int lat, input int fault);
    int v;
    for (int k = 0; k < 64; k++) begin
      en_arr[k] = 1'b0;
      rst_arr[k] = 1'b0;
    end
    for (int k = 1; k <= n + lat; k++) begin
      case (mode)
        0: en_arr[k] = 1'b1;
        1: begin en_arr[k] = (k <= 8); rst_arr[k] = (k == 5); end
        2: en_arr[k] = (k != 1);
        3: begin
          en_arr[k]  = 1'($urandom_range(0, 1));
          rst_arr[k] = ($urandom_range(0, 7) == 0);
        end
        default: ;
      endcase
    end
    v = 0;
    exp_arr[0] = 4'd0;
    for (int j = 1; j <= n; j++) begin
      if (rst_arr[j]) v = 0;
      else if (en_arr[j]) v = (v + 1) % 16;
      exp_arr[j] = 4'(v);
    end
    for (int j = 0; j < n; j++) begin
      got_arr[j] = exp_arr[j];
      if (mode == 4) got_arr[j] = 4'd15;
      if (mode == 3 && $urandom_range(0, 9) == 0)
        got_arr[j] = exp_arr[j] ^ 4'($urandom_range(1, 15));
      if (j == fault) got_arr[j] = exp_arr[j] & 4'b1011;
    end
  endtask

  task automatic run(input bit s, input int mode, input int n, input int fault,
                     input int abort_at, input bit poke);
    int lat, maxe, ne, fidx, j;
    logic [3:0] fe, fg;
    lat  = s ? 0 : 1;
    maxe = s ? 7 : 255;
    build(mode, n, lat, fault);
    ne = 0; fidx = 0; fe = 4'd0; fg = 4'd0;
    for (int i = 0; i < n; i++) begin
      if (got_arr[i] !== exp_arr[i]) begin
        if (ne == 0) begin fidx = i; fe = exp_arr[i]; fg = got_arr[i]; end
        ne++;
      end
    end
    if (ne > maxe) ne = maxe;

    sel = s; num = 16'(n); en = 1'b0; rst = 1'b0; cnt = 4'd0;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 1; k <= lat + n; k++) begin
      j = k - 1 - lat;
      chk("busy_in_run", 32'(c_busy), 32'd1);
      chk("done_early", 32'(c_done), 32'd0);
      if (j >= 0) chk("exp_count", 32'(c_exp), 32'(exp_arr[j]));
      if (j == abort_at) begin
        rstn = 1'b0;
        #1;
        chk("abort_busy", 32'(c_busy), 32'd0);
        chk("abort_done", 32'(c_done), 32'd0);
        chk("abort_pass", 32'(c_pass), 32'd0);
        chk("abort_err", 32'(c_err), 32'd0);
        chk("abort_fec", 32'(c_fec), 32'd0);
        chk("abort_fee", 32'(c_fee), 32'd0);
        chk("abort_feg", 32'(c_feg), 32'd0);
        chk("abort_exp", 32'(c_exp), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_abort_done", 32'(c_done), 32'd0);
        chk("post_abort_busy", 32'(c_busy), 32'd0);
        return;
      end
      en = en_arr[k]; rst = rst_arr[k];
      cnt = (j >= 0) ? got_arr[j] : 4'd0;
      if (poke && k == 2) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
        num = 16'd3;
      end
      tick();
      start_a = 1'b0; start_b = 1'b0;
    end
    en = 1'b0; rst = 1'b0; cnt = 4'd0;
    chk("done_pulse", 32'(c_done), 32'd1);
    chk("busy_at_done", 32'(c_busy), 32'd0);
    chk("pass", 32'(c_pass), 32'(ne == 0));
    chk("err_cnt", 32'(c_err), 32'(ne));
    chk("first_err_cycle", 32'(c_fec), 32'(fidx));
    chk("first_err_exp", 32'(c_fee), 32'(fe));
    chk("first_err_got", 32'(c_feg), 32'(fg));
    tick();
    chk("done_one_cycle", 32'(c_done), 32'd0);
    chk("idle_busy", 32'(c_busy), 32'd0);
    chk("pass_hold", 32'(c_pass), 32'(ne == 0));
    chk("err_hold", 32'(c_err), 32'(ne));
  endtask

  initial begin
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; num = 16'd0;
    en = 1'b0; rst = 1'b0; cnt = 4'd0; sel = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_busy", 32'(c_busy), 32'd0);
      chk("rst_done", 32'(c_done), 32'd0);
      chk("rst_pass", 32'(c_pass), 32'd0);
      chk("rst_err", 32'(c_err), 32'd0);
      chk("rst_fec", 32'(c_fec), 32'd0);
      chk("rst_exp", 32'(c_exp), 32'd0);
    end
    rstn = 1'b1;
    tick();

    run(1'b0, 0, 20, -1, -1, 1'b1);  // clean count with wrap, start poked mid-run
    run(1'b0, 1, 12, -1, -1, 1'b0);  // clear beats increment
    run(1'b0, 2, 10, 7, -1, 1'b0);   // single bit-2 fault at index 7
    run(1'b1, 4, 20, -1, -1, 1'b0);  // stuck readout saturates 3-bit counter
    run(1'b1, 0, 0, -1, -1, 1'b0);   // zero length, LAT=0
    run(1'b0, 0, 0, -1, -1, 1'b0);   // zero length, LAT=1
    run(1'b0, 3, 15, -1, 4, 1'b0);   // reset mid-run
    run(1'b0, 0, 8, -1, -1, 1'b0);   // normal run after abort
    for (int r = 0; r < 6; r++) begin
      run(1'(r % 2), 3, int'($urandom_range(1, 30)), -1, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
